// File: rtl/proc_ctrl_if.sv
// Control/datapath boundary of the TinyRV1 five-stage pipeline.
// d2c_*: status from the datapath (fetched instruction, X-stage equality flag).
// c2d_*: per-stage controls driven by proc_ctrl (fetch, PC select, bypass, writeback).
// master = control unit, slave = datapath.
interface proc_ctrl_if;
  logic [31:0] d2c_inst;
  logic        d2c_eq_X;
  logic        c2d_imemreq_val;
  logic        c2d_reg_en_F;
  logic [1:0]  c2d_pc_sel_F;
  logic        c2d_reg_en_D;
  logic [1:0]  c2d_op1_byp_sel_D;
  logic [1:0]  c2d_op2_byp_sel_D;
  logic        c2d_op1_sel_D;
  logic        c2d_op2_sel_D;
  logic        c2d_alu_fn_X;
  logic        c2d_result_sel_X;
  logic        c2d_wb_sel_M;
  logic        c2d_rf_wen_W;
  logic [4:0]  c2d_rf_waddr_W;

  modport master (
    input  d2c_inst, d2c_eq_X,
    output c2d_imemreq_val, c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D,
           c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
           c2d_alu_fn_X, c2d_result_sel_X, c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W
  );

  modport slave (
    output d2c_inst, d2c_eq_X,
    input  c2d_imemreq_val, c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D,
           c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
           c2d_alu_fn_X, c2d_result_sel_X, c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W
  );
endinterface

// File: rtl/proc_ctrl.sv
// Control unit for the TinyRV1 F/D/X/M/W pipeline: decode, bypass, stall, squash, writeback.
// Latency: decode in D, controls registered per stage; bne resolves in X (2-cycle penalty), jal/jr in D (1 cycle).
// Backpressure: load-use stalls F and D for one cycle and injects a bubble into X.
// Ports: clk, rst (async active-low), dp (proc_ctrl_if.master: d2c_* in, c2d_* out).
// Optional: PROC_CTRL_PERF_CNT_EN adds perf_num_insts / perf_num_stalls counters.
module proc_ctrl (
  input  logic        clk,
  input  logic        rst,
  proc_ctrl_if.master dp
`ifdef PROC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_num_insts,
  output logic [31:0] perf_num_stalls
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // run goes high on the first edge after reset and enables fetching.
  logic       run;
  logic       val_D;
  logic       val_X, rd_wen_X, alu_fn_X, result_sel_X, is_load_X, is_bne_X;
  logic [4:0] rd_X;
  logic       val_M, rd_wen_M, is_load_M;
  logic [4:0] rd_M;
  logic       val_W, rd_wen_W;
  logic [4:0] rd_W;

  logic [4:0] rs1_D, rs2_D, rd_D;
  logic [2:0] funct3_D;
  logic [6:0] funct7_D;
  logic       rs1_en_D, rs2_en_D, rd_wen_D, op1_sel_D, op2_sel_D;
  logic       alu_fn_D, result_sel_D, is_load_D, is_bne_D, is_jal_D, is_jr_D;

  assign rs1_D    = dp.d2c_inst[19:15];
  assign rs2_D    = dp.d2c_inst[24:20];
  assign rd_D     = dp.d2c_inst[11:7];
  assign funct3_D = dp.d2c_inst[14:12];
  assign funct7_D = dp.d2c_inst[31:25];

  // Decode; an invalid D slot or an unsupported encoding yields all-zero controls (NOP).
  always_comb begin
    rs1_en_D = 1'b0; rs2_en_D = 1'b0; rd_wen_D = 1'b0;
    op1_sel_D = 1'b0; op2_sel_D = 1'b0; alu_fn_D = 1'b0; result_sel_D = 1'b0;
    is_load_D = 1'b0; is_bne_D = 1'b0; is_jal_D = 1'b0; is_jr_D = 1'b0;
    if (val_D) begin
      case (dp.d2c_inst[6:0])
        OPC_OP: begin
          if (funct3_D == 3'b000 && (funct7_D == 7'd0 || funct7_D == 7'd1)) begin
            rs1_en_D = 1'b1; rs2_en_D = 1'b1; rd_wen_D = 1'b1;
            result_sel_D = (funct7_D == 7'd1);
          end
        end
        OPC_OPIMM: if (funct3_D == 3'b000) begin
          rs1_en_D = 1'b1; rd_wen_D = 1'b1; op2_sel_D = 1'b1;
        end
        OPC_LOAD: if (funct3_D == 3'b010) begin
          rs1_en_D = 1'b1; rd_wen_D = 1'b1; op2_sel_D = 1'b1; is_load_D = 1'b1;
        end
        OPC_STORE: if (funct3_D == 3'b010) begin
          rs1_en_D = 1'b1; rs2_en_D = 1'b1; op2_sel_D = 1'b1;
        end
        OPC_JAL: begin
          rd_wen_D = 1'b1; op1_sel_D = 1'b1; op2_sel_D = 1'b1; is_jal_D = 1'b1;
        end
        OPC_JALR: if (funct3_D == 3'b000) begin
          rs1_en_D = 1'b1; is_jr_D = 1'b1;
        end
        OPC_BRANCH: if (funct3_D == 3'b001) begin
          rs1_en_D = 1'b1; rs2_en_D = 1'b1; alu_fn_D = 1'b1; is_bne_D = 1'b1;
        end
        default: ;
      endcase
      if (rd_D == 5'd0) rd_wen_D = 1'b0;
    end
  end

  logic wr_X, wr_M, wr_W;
  logic ld_use, br_taken, stall_D, jump_D, val_D_next, val_X_next;

  always_comb begin
    wr_X     = val_X & rd_wen_X;
    wr_M     = val_M & rd_wen_M;
    wr_W     = val_W & rd_wen_W;
    ld_use   = wr_X & is_load_X &
               ((rs1_en_D & (rs1_D == rd_X)) | (rs2_en_D & (rs2_D == rd_X)));
    br_taken = val_X & is_bne_X & ~dp.d2c_eq_X;
    // A taken branch squashes D, so it wins over both the stall and a D jump.
    stall_D  = ld_use & ~br_taken;
    jump_D   = (is_jal_D | is_jr_D) & ~ld_use & ~br_taken;
    val_X_next = val_D & ~ld_use & ~br_taken;
    if (br_taken)     val_D_next = 1'b0;
    else if (stall_D) val_D_next = val_D;
    else if (jump_D)  val_D_next = 1'b0;
    else              val_D_next = run;
  end

  // Youngest writer wins; a load still in X has no data yet, the stall covers it.
  function automatic logic [1:0] byp_sel(input logic en, input logic [4:0] rs,
                                         input logic hit_x, input logic hit_m,
                                         input logic hit_w, input logic load_x);
    byp_sel = 2'd0;
    if (en && rs != 5'd0) begin
      if (hit_x)      byp_sel = load_x ? 2'd0 : 2'd1;
      else if (hit_m) byp_sel = 2'd2;
      else if (hit_w) byp_sel = 2'd3;
    end
  endfunction

  always_comb begin
    dp.c2d_imemreq_val   = run;
    dp.c2d_reg_en_F      = run & ~stall_D;
    dp.c2d_reg_en_D      = run & ~stall_D;
    dp.c2d_pc_sel_F      = 2'd0;
    if (br_taken)    dp.c2d_pc_sel_F = 2'd1;
    else if (jump_D) dp.c2d_pc_sel_F = is_jal_D ? 2'd2 : 2'd3;
    dp.c2d_op1_byp_sel_D = byp_sel(rs1_en_D, rs1_D, wr_X && rd_X == rs1_D,
                                   wr_M && rd_M == rs1_D, wr_W && rd_W == rs1_D, is_load_X);
    dp.c2d_op2_byp_sel_D = byp_sel(rs2_en_D, rs2_D, wr_X && rd_X == rs2_D,
                                   wr_M && rd_M == rs2_D, wr_W && rd_W == rs2_D, is_load_X);
    dp.c2d_op1_sel_D     = op1_sel_D;
    dp.c2d_op2_sel_D     = op2_sel_D;
    dp.c2d_alu_fn_X      = alu_fn_X;
    dp.c2d_result_sel_X  = result_sel_X;
    dp.c2d_wb_sel_M      = is_load_M;
    dp.c2d_rf_wen_W      = wr_W;
    dp.c2d_rf_waddr_W    = rd_W;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run <= 1'b0; val_D <= 1'b0;
      val_X <= 1'b0; rd_X <= '0; rd_wen_X <= 1'b0; alu_fn_X <= 1'b0;
      result_sel_X <= 1'b0; is_load_X <= 1'b0; is_bne_X <= 1'b0;
      val_M <= 1'b0; rd_M <= '0; rd_wen_M <= 1'b0; is_load_M <= 1'b0;
      val_W <= 1'b0; rd_W <= '0; rd_wen_W <= 1'b0;
    end else begin
      run          <= 1'b1;
      val_D        <= val_D_next;
      val_X        <= val_X_next;
      rd_X         <= val_X_next ? rd_D : 5'd0;
      rd_wen_X     <= val_X_next & rd_wen_D;
      alu_fn_X     <= val_X_next & alu_fn_D;
      result_sel_X <= val_X_next & result_sel_D;
      is_load_X    <= val_X_next & is_load_D;
      is_bne_X     <= val_X_next & is_bne_D;
      val_M        <= val_X;
      rd_M         <= rd_X;
      rd_wen_M     <= rd_wen_X;
      is_load_M    <= is_load_X;
      val_W        <= val_M;
      rd_W         <= rd_M;
      rd_wen_W     <= rd_wen_M;
    end
  end

`ifdef PROC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_num_insts  <= '0;
      perf_num_stalls <= '0;
    end else begin
      if (val_W)   perf_num_insts  <= perf_num_insts + 32'd1;
      if (stall_D) perf_num_stalls <= perf_num_stalls + 32'd1;
    end
  end
`endif

endmodule
